// File: rtl/general_defines.sv
// Shared widths and the reorder-buffer entry payload used across the core.
package general_defines;

    localparam int unsigned ROB_IDX_W       = 3;
    localparam int unsigned INSTR_MEM_IDX_W = 10;
    localparam int unsigned ARCH_REG_IDX_W  = 5;
    localparam int unsigned PHYS_REG_IDX_W  = 6;
    localparam int unsigned INT_DATA_W      = 32;

    typedef struct packed {
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [ARCH_REG_IDX_W-1:0]  logical_rd;
        logic [PHYS_REG_IDX_W-1:0]  phys_rd;
        logic [PHYS_REG_IDX_W-1:0]  old_phys_rd;
        logic [INT_DATA_W-1:0]      result;
        logic [6:0]                 opcode;
        logic [2:0]                 funct3;
        logic [6:0]                 funct7;
        logic                       is_store;
        logic                       is_load;
        logic                       is_branch;
        logic                       pred_taken;
        logic [INSTR_MEM_IDX_W-1:0] pred_target;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order retire, full flush.
// Define ROB_WB_BYPASS_EN to forward a writeback that targets the head onto the head outputs in the same cycle.
module reorder_buffer
    import general_defines::*;
#(
    parameter int unsigned ROB_DEPTH = 1 << ROB_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [ROB_IDX_W-1:0]       alloc_idx,
    input  logic [INSTR_MEM_IDX_W-1:0] alloc_pc,
    input  logic [ARCH_REG_IDX_W-1:0]  alloc_logical_rd,
    input  logic [PHYS_REG_IDX_W-1:0]  alloc_phys_rd,
    input  logic [PHYS_REG_IDX_W-1:0]  alloc_old_phys_rd,
    input  logic [6:0]                 alloc_opcode,
    input  logic [2:0]                 alloc_funct3,
    input  logic [6:0]                 alloc_funct7,
    input  logic                       alloc_is_store,
    input  logic                       alloc_is_load,
    input  logic                       alloc_is_branch,
    input  logic                       alloc_pred_taken,
    input  logic [INSTR_MEM_IDX_W-1:0] alloc_pred_target,

    input  logic                       wb_valid,
    input  logic [ROB_IDX_W-1:0]       wb_rob_idx,
    input  logic [INT_DATA_W-1:0]      wb_result,
    input  logic                       wb_branch_taken,
    input  logic [INSTR_MEM_IDX_W-1:0] wb_branch_target,

    output logic [ROB_IDX_W-1:0]       rob_head_idx,
    output logic                       rob_head_valid,
    output logic                       rob_head_done,
    output logic [INSTR_MEM_IDX_W-1:0] rob_head_pc,
    output logic [ARCH_REG_IDX_W-1:0]  rob_head_logical_rd,
    output logic [PHYS_REG_IDX_W-1:0]  rob_head_phys_rd,
    output logic [PHYS_REG_IDX_W-1:0]  rob_head_old_phys_rd,
    output logic [INT_DATA_W-1:0]      rob_head_result,
    output logic [6:0]                 rob_head_opcode,
    output logic [2:0]                 rob_head_funct3,
    output logic [6:0]                 rob_head_funct7,
    output logic                       rob_head_is_store,
    output logic                       rob_head_is_load,
    output logic                       rob_head_is_branch,
    output logic                       rob_head_pred_taken,
    output logic [INSTR_MEM_IDX_W-1:0] rob_head_pred_target,
    output logic                       rob_head_branch_taken,
    output logic [INSTR_MEM_IDX_W-1:0] rob_head_branch_target,

    input  logic                       rob_advance_head,
    input  logic                       flush_pipeline,

    output logic                       rob_full,
    output logic                       rob_empty,
    output logic [ROB_IDX_W:0]         rob_count
);

    localparam int unsigned CNT_W = ROB_IDX_W + 1;

    if (ROB_DEPTH != (1 << ROB_IDX_W)) begin : g_bad_depth
        $error("reorder_buffer: ROB_DEPTH must equal 2**ROB_IDX_W");
    end

    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] tail;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    rob_entry_t           entries [ROB_DEPTH];

    logic       alloc_fire;
    logic       wb_fire;
    logic       retire_fire;
    logic       wb_hits_head;
    rob_entry_t alloc_entry;
    rob_entry_t head_view;

    assign rob_full       = (count == CNT_W'(ROB_DEPTH));
    assign rob_empty      = (count == '0);
    assign rob_count      = count;
    assign alloc_ready    = !rob_full;
    assign alloc_idx      = tail;
    assign rob_head_idx   = head;
    assign rob_head_valid = !rob_empty;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign retire_fire = rob_advance_head && rob_head_valid;
    // Allocation owns the tail slot if a writeback illegally aims at it.
    assign wb_fire     = wb_valid && valid[wb_rob_idx] && !(alloc_fire && (wb_rob_idx == tail));

    always_comb begin
        alloc_entry               = '0;
        alloc_entry.pc            = alloc_pc;
        alloc_entry.logical_rd    = alloc_logical_rd;
        alloc_entry.phys_rd       = alloc_phys_rd;
        alloc_entry.old_phys_rd   = alloc_old_phys_rd;
        alloc_entry.opcode        = alloc_opcode;
        alloc_entry.funct3        = alloc_funct3;
        alloc_entry.funct7        = alloc_funct7;
        alloc_entry.is_store      = alloc_is_store;
        alloc_entry.is_load       = alloc_is_load;
        alloc_entry.is_branch     = alloc_is_branch;
        alloc_entry.pred_taken    = alloc_pred_taken;
        alloc_entry.pred_target   = alloc_pred_target;
    end

    always_comb begin
        count_nxt = count;
        case ({alloc_fire, retire_fire})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Control state; flush shares the reset path so it beats alloc, writeback and retire.
    always_ff @(posedge clk) begin
        if (rst || flush_pipeline) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + ROB_IDX_W'(1);
            end
            if (wb_fire) begin
                done[wb_rob_idx] <= 1'b1;
            end
            if (retire_fire) begin
                valid[head] <= 1'b0;
                head        <= head + ROB_IDX_W'(1);
            end
            count <= count_nxt;
        end
    end

    // Payload storage is not reset; every read is gated by valid.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            entries[tail] <= alloc_entry;
        end
        if (wb_fire) begin
            entries[wb_rob_idx].result        <= wb_result;
            entries[wb_rob_idx].branch_taken  <= wb_branch_taken;
            entries[wb_rob_idx].branch_target <= wb_branch_target;
        end
    end

`ifdef ROB_WB_BYPASS_EN
    assign wb_hits_head = wb_valid && rob_head_valid && valid[head] && (wb_rob_idx == head);
`else
    assign wb_hits_head = 1'b0;
`endif

    assign head_view = rob_head_valid ? entries[head] : '0;

    assign rob_head_done          = rob_head_valid && (done[head] || wb_hits_head);
    assign rob_head_pc            = head_view.pc;
    assign rob_head_logical_rd    = head_view.logical_rd;
    assign rob_head_phys_rd       = head_view.phys_rd;
    assign rob_head_old_phys_rd   = head_view.old_phys_rd;
    assign rob_head_result        = wb_hits_head ? wb_result        : head_view.result;
    assign rob_head_opcode        = head_view.opcode;
    assign rob_head_funct3        = head_view.funct3;
    assign rob_head_funct7        = head_view.funct7;
    assign rob_head_is_store      = head_view.is_store;
    assign rob_head_is_load       = head_view.is_load;
    assign rob_head_is_branch     = head_view.is_branch;
    assign rob_head_pred_taken    = head_view.pred_taken;
    assign rob_head_pred_target   = head_view.pred_target;
    assign rob_head_branch_taken  = wb_hits_head ? wb_branch_taken  : head_view.branch_taken;
    assign rob_head_branch_target = wb_hits_head ? wb_branch_target : head_view.branch_target;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (ROB_DEPTH = 8 with the shared widths).
module tb_reorder_buffer;
    import general_defines::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       alloc_valid;
    logic                       alloc_ready;
    logic [ROB_IDX_W-1:0]       alloc_idx;
    logic [INSTR_MEM_IDX_W-1:0] alloc_pc;
    logic [ARCH_REG_IDX_W-1:0]  alloc_logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  alloc_phys_rd;
    logic [PHYS_REG_IDX_W-1:0]  alloc_old_phys_rd;
    logic [6:0]                 alloc_opcode;
    logic [2:0]                 alloc_funct3;
    logic [6:0]                 alloc_funct7;
    logic                       alloc_is_store;
    logic                       alloc_is_load;
    logic                       alloc_is_branch;
    logic                       alloc_pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] alloc_pred_target;
    logic                       wb_valid;
    logic [ROB_IDX_W-1:0]       wb_rob_idx;
    logic [INT_DATA_W-1:0]      wb_result;
    logic                       wb_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] wb_branch_target;
    logic [ROB_IDX_W-1:0]       rob_head_idx;
    logic                       rob_head_valid;
    logic                       rob_head_done;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_pc;
    logic [ARCH_REG_IDX_W-1:0]  rob_head_logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  rob_head_phys_rd;
    logic [PHYS_REG_IDX_W-1:0]  rob_head_old_phys_rd;
    logic [INT_DATA_W-1:0]      rob_head_result;
    logic [6:0]                 rob_head_opcode;
    logic [2:0]                 rob_head_funct3;
    logic [6:0]                 rob_head_funct7;
    logic                       rob_head_is_store;
    logic                       rob_head_is_load;
    logic                       rob_head_is_branch;
    logic                       rob_head_pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_pred_target;
    logic                       rob_head_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] rob_head_branch_target;
    logic                       rob_advance_head;
    logic                       flush_pipeline;
    logic                       rob_full;
    logic                       rob_empty;
    logic [ROB_IDX_W:0]         rob_count;

    int tests = 0;
    int fails = 0;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .alloc_pc(alloc_pc), .alloc_logical_rd(alloc_logical_rd),
        .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys_rd(alloc_old_phys_rd),
        .alloc_opcode(alloc_opcode), .alloc_funct3(alloc_funct3), .alloc_funct7(alloc_funct7),
        .alloc_is_store(alloc_is_store), .alloc_is_load(alloc_is_load),
        .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
        .alloc_pred_target(alloc_pred_target),
        .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_result(wb_result),
        .wb_branch_taken(wb_branch_taken), .wb_branch_target(wb_branch_target),
        .rob_head_idx(rob_head_idx), .rob_head_valid(rob_head_valid), .rob_head_done(rob_head_done),
        .rob_head_pc(rob_head_pc), .rob_head_logical_rd(rob_head_logical_rd),
        .rob_head_phys_rd(rob_head_phys_rd), .rob_head_old_phys_rd(rob_head_old_phys_rd),
        .rob_head_result(rob_head_result), .rob_head_opcode(rob_head_opcode),
        .rob_head_funct3(rob_head_funct3), .rob_head_funct7(rob_head_funct7),
        .rob_head_is_store(rob_head_is_store), .rob_head_is_load(rob_head_is_load),
        .rob_head_is_branch(rob_head_is_branch), .rob_head_pred_taken(rob_head_pred_taken),
        .rob_head_pred_target(rob_head_pred_target), .rob_head_branch_taken(rob_head_branch_taken),
        .rob_head_branch_target(rob_head_branch_target),
        .rob_advance_head(rob_advance_head), .flush_pipeline(flush_pipeline),
        .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_pc = '0; alloc_logical_rd = '0; alloc_phys_rd = '0;
        alloc_old_phys_rd = '0; alloc_opcode = '0; alloc_funct3 = '0; alloc_funct7 = '0;
        alloc_is_store = 0; alloc_is_load = 0; alloc_is_branch = 0; alloc_pred_taken = 0;
        alloc_pred_target = '0; wb_valid = 0; wb_rob_idx = '0; wb_result = '0;
        wb_branch_taken = 0; wb_branch_target = '0; rob_advance_head = 0; flush_pipeline = 0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input int pc);
        alloc_valid       = 1;
        alloc_pc          = INSTR_MEM_IDX_W'(pc);
        alloc_logical_rd  = ARCH_REG_IDX_W'(pc);
        alloc_phys_rd     = PHYS_REG_IDX_W'(pc + 1);
        alloc_opcode      = 7'h33;
    endtask

    task automatic set_wb(input int idx, input int res);
        wb_valid         = 1;
        wb_rob_idx       = ROB_IDX_W'(idx);
        wb_result        = INT_DATA_W'(res);
        wb_branch_taken  = 1;
        wb_branch_target = INSTR_MEM_IDX_W'(res);
    endtask

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        chk("reset_empty", 64'(rob_empty), 64'd1);
        chk("reset_full", 64'(rob_full), 64'd0);
        chk("reset_ready", 64'(alloc_ready), 64'd1);
        chk("reset_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("reset_head_valid", 64'(rob_head_valid), 64'd0);
        chk("reset_head_done", 64'(rob_head_done), 64'd0);
        chk("reset_head_pc", 64'(rob_head_pc), 64'd0);
        chk("reset_count", 64'(rob_count), 64'd0);

        // Three allocations at pc 4,5,6.
        for (int i = 0; i < 3; i++) begin
            set_alloc(4 + i);
            chk("alloc_idx_seq", 64'(alloc_idx), 64'(i));
            cyc();
        end
        idle();
        chk("count3", 64'(rob_count), 64'd3);
        chk("head_pc4", 64'(rob_head_pc), 64'd4);
        chk("head_phys_rd", 64'(rob_head_phys_rd), 64'd5);
        chk("head_not_done", 64'(rob_head_done), 64'd0);

        // Younger writeback does not complete the head.
        set_wb(1, 'h11);
        cyc();
        idle();
        chk("head_done_after_wb1", 64'(rob_head_done), 64'd0);
        set_wb(0, 'hAA);
        #1;
        chk("head_done_wb0_same_cycle", 64'(rob_head_done), 64'(BYPASS));
        cyc();
        idle();
        chk("head_done_after_wb0", 64'(rob_head_done), 64'd1);
        chk("head_result_aa", 64'(rob_head_result), 64'hAA);
        chk("head_br_taken", 64'(rob_head_branch_taken), 64'd1);
        rob_advance_head = 1;
        cyc();
        idle();
        chk("adv_head_idx1", 64'(rob_head_idx), 64'd1);
        chk("adv_head_done", 64'(rob_head_done), 64'd1);
        chk("adv_head_result", 64'(rob_head_result), 64'h11);
        chk("adv_count2", 64'(rob_count), 64'd2);

        // Drain, leaving head = tail = 3.
        rob_advance_head = 1;
        cyc(); cyc();
        idle();
        chk("drained_empty", 64'(rob_empty), 64'd1);

        // Fill all eight slots starting at index 3.
        for (int i = 0; i < 8; i++) begin
            set_alloc(100 + i);
            cyc();
        end
        idle();
        chk("full", 64'(rob_full), 64'd1);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_count", 64'(rob_count), 64'd8);
        set_alloc(999);
        cyc();
        idle();
        chk("drop_count", 64'(rob_count), 64'd8);
        chk("drop_alloc_idx", 64'(alloc_idx), 64'd3);
        chk("drop_head_pc", 64'(rob_head_pc), 64'd100);
        set_alloc(998);
        rob_advance_head = 1;
        #1;
        chk("retire_ready_still_low", 64'(alloc_ready), 64'd0);
        cyc();
        idle();
        chk("retire_count7", 64'(rob_count), 64'd7);
        chk("retire_ready_back", 64'(alloc_ready), 64'd1);
        chk("retire_head_pc", 64'(rob_head_pc), 64'd101);
        flush_pipeline = 1;
        cyc();
        idle();
        chk("flush_full_empty", 64'(rob_empty), 64'd1);

        // Sixteen alloc/retire pairs with one entry resident.
        set_alloc(200);
        cyc();
        for (int i = 1; i <= 16; i++) begin
            set_alloc(200 + i);
            rob_advance_head = 1;
            cyc();
            chk("pair_count", 64'(rob_count), 64'd1);
        end
        idle();
        chk("wrap_head_idx", 64'(rob_head_idx), 64'd0);
        chk("wrap_alloc_idx", 64'(alloc_idx), 64'd1);
        chk("wrap_head_pc", 64'(rob_head_pc), 64'd216);

        // Retire the last one, then advance on empty is ignored.
        rob_advance_head = 1;
        cyc();
        cyc();
        idle();
        chk("empty_adv_count", 64'(rob_count), 64'd0);
        chk("empty_adv_head_idx", 64'(rob_head_idx), 64'd1);

        // Five entries, then flush together with advance and alloc.
        for (int i = 0; i < 5; i++) begin
            set_alloc(300 + i);
            cyc();
        end
        idle();
        set_wb(1, 7);
        cyc();
        idle();
        chk("five_count", 64'(rob_count), 64'd5);
        chk("five_head_done", 64'(rob_head_done), 64'd1);
        flush_pipeline = 1;
        rob_advance_head = 1;
        set_alloc(350);
        cyc();
        idle();
        chk("flush_empty", 64'(rob_empty), 64'd1);
        chk("flush_count", 64'(rob_count), 64'd0);
        chk("flush_alloc_idx", 64'(alloc_idx), 64'd0);
        chk("flush_head_idx", 64'(rob_head_idx), 64'd0);
        chk("flush_head_done", 64'(rob_head_done), 64'd0);
        set_wb(3, 9);
        cyc();
        idle();
        chk("stale_wb_empty", 64'(rob_empty), 64'd1);
        chk("stale_wb_head_done", 64'(rob_head_done), 64'd0);

        // Writeback to the head: same cycle with bypass, next cycle without.
        set_alloc(400);
        cyc();
        idle();
        chk("bp_head_pc", 64'(rob_head_pc), 64'd400);
        chk("bp_head_done_pre", 64'(rob_head_done), 64'd0);
        set_wb(0, 'h55);
        #1;
        chk("bp_done_same_cycle", 64'(rob_head_done), 64'(BYPASS));
        chk("bp_result_same_cycle", 64'(rob_head_result), BYPASS ? 64'h55 : 64'h0);
        cyc();
        idle();
        chk("bp_done_next", 64'(rob_head_done), 64'd1);
        chk("bp_result_next", 64'(rob_head_result), 64'h55);

        // Reset mid-operation discards entries.
        set_alloc(401);
        cyc();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_empty", 64'(rob_empty), 64'd1);
        chk("midrst_count", 64'(rob_count), 64'd0);
        chk("midrst_head_valid", 64'(rob_head_valid), 64'd0);
        chk("midrst_head_pc", 64'(rob_head_pc), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between dispatch/rename and the commit stage. It allocates one entry per dispatched instruction in program order and records execution results from the writeback bus. It presents the oldest entry (the head) to commit and retires it when commit pulses `rob_advance_head`. A pipeline flush from commit squashes every in-flight entry.

## Interface
Parameters:
- `ROB_DEPTH`, default `1 << ROB_IDX_W`: number of entries. Must equal `2**ROB_IDX_W`; any other value is a hard error.

Ports:
- `clk` in 1: clock, single domain.
- `rst` in 1: reset, synchronous, active-high.
- `alloc_valid` in 1: dispatch offers an instruction.
- `alloc_ready` out 1: an entry can be accepted; equals `!rob_full`.
- `alloc_idx` out ROB_IDX_W: index the offered instruction receives (current tail).
- `alloc_pc` in INSTR_MEM_IDX_W; `alloc_logical_rd` in ARCH_REG_IDX_W; `alloc_phys_rd`, `alloc_old_phys_rd` in PHYS_REG_IDX_W: rename info.
- `alloc_opcode` in 7; `alloc_funct3` in 3; `alloc_funct7` in 7: decode fields.
- `alloc_is_store`, `alloc_is_load`, `alloc_is_branch`, `alloc_pred_taken` in 1: instruction class and prediction.
- `alloc_pred_target` in INSTR_MEM_IDX_W: predicted target.
- `wb_valid` in 1; `wb_rob_idx` in ROB_IDX_W; `wb_result` in INT_DATA_W: execution result.
- `wb_branch_taken` in 1; `wb_branch_target` in INSTR_MEM_IDX_W: resolved branch outcome.
- `rob_head_idx`, `rob_head_valid`, `rob_head_done`, and `rob_head_*` outs: head fields, one output per stored field, named after the stored field (`pc`, `logical_rd`, `phys_rd`, `old_phys_rd`, `result`, `opcode`, `funct3`, `funct7`, `is_store`, `is_load`, `is_branch`, `pred_taken`, `pred_target`, `branch_taken`, `branch_target`).
- `rob_advance_head` in 1: commit retires the head.
- `flush_pipeline` in 1: squash all entries.
- `rob_full`, `rob_empty` out 1; `rob_count` out ROB_IDX_W+1: occupancy.

## Operation
- State: `head`, `tail` (ROB_IDX_W bits, natural wrap from DEPTH-1 to 0); `count` (ROB_IDX_W+1 bits); per-entry `valid` and `done` bits plus payload.
- Allocate when `alloc_valid && alloc_ready`:
  - Write payload at `tail`; set `valid`=1 and `done`=0.
  - `tail`+1.
- Writeback when `wb_valid` and `valid[wb_rob_idx]`:
  - Store `result`, `branch_taken`, `branch_target`; set `done`=1.
  - A writeback to an invalid entry is ignored.
- Retire when `rob_advance_head && rob_head_valid`:
  - Clear `valid[head]`; `head`+1.
  - `rob_advance_head` while the buffer is empty is ignored.
- Occupancy: `count` += alloc − retire; simultaneous alloc and retire leave it unchanged.
- Status outputs: `rob_full` = (`count`==DEPTH); `rob_empty` = (`count`==0); `rob_head_valid` = !`rob_empty`.
- Flush has priority over alloc, writeback and retire in the same cycle:
  - `head`=`tail`=`count`=0; all `valid`/`done` cleared.
  - Commit asserts flush in the same cycle it retires the mispredicted branch, so that branch is also gone after the flush.
- Writeback and allocate to the same index in one cycle cannot legally occur; allocate wins.

## Timing
- All state is registered on `posedge clk`.
- Reset (`rst`=1, synchronous): `head`/`tail`/`count`=0; all `valid`/`done`=0; `rob_empty`=1; `rob_full`=0; `alloc_ready`=1; `alloc_idx`=0; `rob_head_valid`=0; `rob_head_done`=0. All other `rob_head_*` outputs are 0 (payload RAM is not reset; outputs are gated by valid). Reset mid-operation discards all entries.
- Allocated entry becomes visible at the head, if it is oldest, the cycle after acceptance.
- `alloc_ready` depends on registered `count` only. A retire in the same cycle does not raise it until the next cycle.
- Writeback-to-done latency: one cycle (see Configuration).

## Configuration
- `ROB_WB_BYPASS_EN` defined: when `wb_valid` targets `head` and the entry is valid, `rob_head_done`, `rob_head_result`, `rob_head_branch_taken` and `rob_head_branch_target` reflect the writeback combinationally in the same cycle. Commit may retire the entry that cycle.
- Undefined: head outputs come from registered state only; done is visible one cycle after writeback.

## Structure
- `general_defines` provides `ROB_IDX_W`, `INSTR_MEM_IDX_W`, `ARCH_REG_IDX_W`, `PHYS_REG_IDX_W` and `INT_DATA_W`.
- Add a `rob_entry_t` packed struct to `general_defines` for the per-entry payload.
- Single module; no sub-module. Payload is an array of `rob_entry_t`.

## Test plan
- Reset, then allocate 3 entries at pc 4,5,6 → `alloc_idx` 0,1,2; `rob_count`=3; head pc=4, `rob_head_done`=0.
- Writeback idx 1 then idx 0 with result 0xAA → head done only after idx 0. Advance → head idx 1, already done.
- Fill all DEPTH entries → `rob_full`=1, `alloc_ready`=0. Further `alloc_valid` is dropped. Retire one → ready returns the next cycle.
- Run 2×DEPTH alloc/retire pairs → `head`/`tail` wrap to 0 and `rob_count` stays constant.
- With 5 entries, assert flush together with advance → next cycle `rob_empty`=1, `alloc_idx`=0. A writeback to an old index is ignored.
- With `ROB_WB_BYPASS_EN`, writeback to head → `rob_head_done`=1 in the same cycle. Without it, `rob_head_done`=1 one cycle later.
